// File: rtl/lif_neuron_stdp.sv
// Leaky integrate-and-fire neuron with stored synaptic weights, refractory period,
// weight load/readback port and optional trace-based STDP learning.
// Build option: define NEURON_STDP_EN to include the pre/post traces and STDP weight
// updates; without it the learn input is ignored and weights change only via wload_en.
module lif_neuron_stdp #(
   parameter int unsigned N_INPUTS      = 8,
   parameter int unsigned W_WIDTH       = 8,
   parameter int unsigned V_WIDTH       = 12,
   parameter int unsigned THRESHOLD     = 256,
   parameter int unsigned LEAK_SHIFT    = 3,
   parameter int unsigned REFRAC_CYCLES = 4,
   parameter int unsigned TRACE_WIDTH   = 3,
   parameter int unsigned W_INIT        = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_INPUTS-1:0]         inputs,
   input  logic                        learn,
   input  logic                        wload_en,
   input  logic [$clog2(N_INPUTS)-1:0] wload_idx,
   input  logic [W_WIDTH-1:0]          wload_data,
   input  logic [$clog2(N_INPUTS)-1:0] wrd_idx,
   output logic [W_WIDTH-1:0]          wrd_data,
   output logic                        spike_out,
   output logic [V_WIDTH-1:0]          membrane,
   output logic                        refrac_active
);

   localparam int unsigned IDX_W = $clog2(N_INPUTS);
   // N weights of W_WIDTH bits each sum without overflow in W_WIDTH + IDX_W bits.
   localparam int unsigned SUM_W = W_WIDTH + IDX_W;
   localparam int unsigned EXT_W = ((V_WIDTH > SUM_W) ? V_WIDTH : SUM_W) + 1;
   localparam int unsigned CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

   localparam logic [V_WIDTH-1:0] V_MAX       = '1;
   localparam logic [W_WIDTH-1:0] W_MAX       = '1;
   localparam logic [V_WIDTH-1:0] THR         = V_WIDTH'(THRESHOLD);
   localparam logic [W_WIDTH-1:0] W_RESET     = W_WIDTH'(W_INIT);
   localparam logic [CNT_W-1:0]   REFRAC_LOAD = CNT_W'(REFRAC_CYCLES);

   typedef enum logic [0:0] {StIntegrate, StRefractory} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [V_WIDTH-1:0]   membrane_q, membrane_d;
   logic                 spike_q, spike_d;
   logic [W_WIDTH-1:0]   w_q [N_INPUTS];
   logic [W_WIDTH-1:0]   w_d [N_INPUTS];

   logic [SUM_W-1:0]     sum;
   logic [V_WIDTH-1:0]   leak;
   logic [EXT_W-1:0]     v_ext;
   logic [V_WIDTH-1:0]   v_next;
   logic                 fire;
   logic [N_INPUTS-1:0]  pot, dep;

   // Weighted sum of active synapses using the pre-edge weights.
   always_comb begin
      sum = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (inputs[i]) sum = sum + SUM_W'(w_q[i]);
      end
   end

   // Leaky integration with saturation; leak never exceeds v so no underflow.
   always_comb begin
      leak   = (LEAK_SHIFT == 0) ? '0 : (membrane_q >> LEAK_SHIFT);
      v_ext  = EXT_W'(membrane_q) - EXT_W'(leak) + EXT_W'(sum);
      v_next = (v_ext > EXT_W'(V_MAX)) ? V_MAX : v_ext[V_WIDTH-1:0];
      fire   = (state_q == StIntegrate) && (v_next >= THR);
   end

   // Next-state logic for integrate/refractory behaviour.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      membrane_d = membrane_q;
      spike_d    = 1'b0;
      unique case (state_q)
         StIntegrate: begin
            if (fire) begin
               membrane_d = '0;
               spike_d    = 1'b1;
               cnt_d      = REFRAC_LOAD;
               if (REFRAC_CYCLES > 0) state_d = StRefractory;
            end else begin
               membrane_d = v_next;
            end
         end
         StRefractory: begin
            membrane_d = '0;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = StIntegrate;
         end
         default: state_d = StIntegrate;
      endcase
   end

   // Neuron state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIntegrate;
         cnt_q      <= '0;
         membrane_q <= '0;
         spike_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         membrane_q <= membrane_d;
         spike_q    <= spike_d;
      end
   end

`ifdef NEURON_STDP_EN
   localparam logic [TRACE_WIDTH-1:0] TRACE_MAX = '1;

   logic [TRACE_WIDTH-1:0] pre_trace_q [N_INPUTS];
   logic [TRACE_WIDTH-1:0] pre_trace_d [N_INPUTS];
   logic [TRACE_WIDTH-1:0] post_trace_q, post_trace_d;

   // Trace decay/refresh and per-synapse STDP decisions from pre-edge traces.
   always_comb begin
      post_trace_d = fire ? TRACE_MAX :
                     ((post_trace_q != '0) ? post_trace_q - 1'b1 : '0);
      for (int i = 0; i < N_INPUTS; i++) begin
         pre_trace_d[i] = inputs[i] ? TRACE_MAX :
                          ((pre_trace_q[i] != '0) ? pre_trace_q[i] - 1'b1 : '0);
         pot[i] = learn && fire && ((pre_trace_q[i] != '0) || inputs[i]);
         dep[i] = learn && inputs[i] && (post_trace_q != '0);
      end
   end

   // Trace registers, running regardless of neuron state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         post_trace_q <= '0;
         for (int i = 0; i < N_INPUTS; i++) pre_trace_q[i] <= '0;
      end else begin
         post_trace_q <= post_trace_d;
         for (int i = 0; i < N_INPUTS; i++) pre_trace_q[i] <= pre_trace_d[i];
      end
   end
`else
   logic unused_learn;
   assign unused_learn = learn;
   assign pot = '0;
   assign dep = '0;
`endif

   // Weight update: saturating STDP step, overridden per index by an explicit load.
   always_comb begin
      for (int i = 0; i < N_INPUTS; i++) begin
         w_d[i] = w_q[i];
         if (pot[i] && !dep[i] && (w_q[i] != W_MAX)) begin
            w_d[i] = w_q[i] + 1'b1;
         end else if (dep[i] && !pot[i] && (w_q[i] != '0)) begin
            w_d[i] = w_q[i] - 1'b1;
         end
         // Out-of-range indices match no synapse, so such writes are dropped.
         if (wload_en && (wload_idx == IDX_W'(i))) w_d[i] = wload_data;
      end
   end

   // Weight storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_INPUTS; i++) w_q[i] <= W_RESET;
      end else begin
         for (int i = 0; i < N_INPUTS; i++) w_q[i] <= w_d[i];
      end
   end

   // Combinational readback; out-of-range index reads as zero.
   always_comb begin
      wrd_data = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (wrd_idx == IDX_W'(i)) wrd_data = w_q[i];
      end
   end

   assign spike_out     = spike_q;
   assign membrane      = membrane_q;
   assign refrac_active = (state_q == StRefractory);

endmodule

// File: tb/tb_lif_neuron_stdp.sv
// Self-checking bench for lif_neuron_stdp with a cycle-level behavioural model.
// Honours NEURON_STDP_EN the same way as the design build.
module tb_lif_neuron_stdp;

   localparam int N    = 8;
   localparam int WMAX = 255;
   localparam int VMAX = 4095;
   localparam int THR  = 256;
   localparam int LS   = 3;
   localparam int RC   = 4;
   localparam int TMAX = 7;
   localparam int WI   = 32;
`ifdef NEURON_STDP_EN
   localparam bit STDP = 1'b1;
`else
   localparam bit STDP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  inputs;
   logic        learn;
   logic        wload_en;
   logic [2:0]  wload_idx;
   logic [7:0]  wload_data;
   logic [2:0]  wrd_idx;
   logic [7:0]  wrd_data;
   logic        spike_out;
   logic [11:0] membrane;
   logic        refrac_active;

   int total = 0;
   int bad   = 0;

   // Model state: membrane value, last spike, refractory cycles left, traces, weights.
   int m_v, m_spike, m_left, m_post;
   int m_w   [N];
   int m_pre [N];

   lif_neuron_stdp dut (
      .clk           (clk),
      .reset         (reset),
      .inputs        (inputs),
      .learn         (learn),
      .wload_en      (wload_en),
      .wload_idx     (wload_idx),
      .wload_data    (wload_data),
      .wrd_idx       (wrd_idx),
      .wrd_data      (wrd_data),
      .spike_out     (spike_out),
      .membrane      (membrane),
      .refrac_active (refrac_active)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_v = 0; m_spike = 0; m_left = 0; m_post = 0;
      for (int i = 0; i < N; i++) begin
         m_w[i] = WI;
         m_pre[i] = 0;
      end
   endtask

   task automatic model_step(input logic [7:0] in, input logic lrn, input logic we,
                             input int widx, input int wdata);
      int sum, vn, d;
      bit fire;
      sum = 0;
      for (int i = 0; i < N; i++) if (in[i]) sum += m_w[i];
      fire = 1'b0;
      if (m_left == 0) begin
         vn = m_v - ((LS > 0) ? (m_v >> LS) : 0) + sum;
         if (vn > VMAX) vn = VMAX;
         if (vn >= THR) begin
            fire = 1'b1; m_v = 0; m_left = RC;
         end else begin
            m_v = vn;
         end
      end else begin
         m_left--; m_v = 0;
      end
      m_spike = fire ? 1 : 0;
      if (STDP && lrn) begin
         for (int i = 0; i < N; i++) begin
            d = 0;
            if (fire && (m_pre[i] > 0 || in[i])) d++;
            if (in[i] && m_post > 0) d--;
            m_w[i] += d;
            if (m_w[i] > WMAX) m_w[i] = WMAX;
            if (m_w[i] < 0) m_w[i] = 0;
         end
      end
      for (int i = 0; i < N; i++) m_pre[i] = in[i] ? TMAX : ((m_pre[i] > 0) ? m_pre[i] - 1 : 0);
      m_post = fire ? TMAX : ((m_post > 0) ? m_post - 1 : 0);
      if (we && widx < N) m_w[widx] = wdata;
   endtask

   task automatic step(input logic [7:0] in, input logic lrn, input logic we,
                       input int widx, input int wdata);
      inputs = in; learn = lrn; wload_en = we;
      wload_idx = 3'(widx); wload_data = 8'(wdata);
      model_step(in, lrn, we, widx, wdata);
      @(posedge clk);
      #1;
      wload_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; inputs = '0; learn = 1'b0; wload_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1; inputs = '0; learn = 1'b0; wload_en = 1'b0;
      wload_idx = '0; wload_data = '0; wrd_idx = '0;
      #2;
      total++;
      if (membrane !== 12'd0 || spike_out !== 1'b0 || refrac_active !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs got v=%0d s=%b r=%b want v=0 s=0 r=0",
                  membrane, spike_out, refrac_active);
      end
      for (int i = 0; i < N; i++) begin
         wrd_idx = 3'(i); #1;
         total++;
         if (wrd_data !== 8'(WI)) begin
            bad++; $display("FAIL reset_weight[%0d] got=%0d want=%0d", i, wrd_data, WI);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_single_fire();
      int hi;
      do_reset();
      step(8'hFF, 1'b0, 1'b0, 0, 0);
      total++;
      if (spike_out !== 1'b1 || membrane !== 12'd0 || refrac_active !== 1'b1) begin
         bad++;
         $display("FAIL single_fire got s=%b v=%0d r=%b want s=1 v=0 r=1",
                  spike_out, membrane, refrac_active);
      end
      hi = refrac_active ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
         step(8'h00, 1'b0, 1'b0, 0, 0);
         hi += refrac_active ? 1 : 0;
         total++;
         if (spike_out !== 1'b0) begin
            bad++; $display("FAIL single_fire_pulse k=%0d got s=%b want s=0", k, spike_out);
         end
      end
      total++;
      if (hi != RC || refrac_active !== 1'b0) begin
         bad++;
         $display("FAIL refrac_length got=%0d r_end=%b want=%0d r_end=0", hi, refrac_active, RC);
      end
   endtask

   task automatic test_leak();
      int exp_v [4] = '{128, 112, 98, 86};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step((k == 0) ? 8'h0F : 8'h00, 1'b0, 1'b0, 0, 0);
         total++;
         if (membrane !== 12'(exp_v[k]) || spike_out !== 1'b0) begin
            bad++;
            $display("FAIL leak k=%0d got v=%0d s=%b want v=%0d s=0",
                     k, membrane, spike_out, exp_v[k]);
         end
      end
   endtask

   task automatic test_periodic();
      do_reset();
      for (int k = 0; k < 15; k++) begin
         step(8'hFF, 1'b0, 1'b0, 0, 0);
         total++;
         if (spike_out !== ((k % (RC + 1)) == 0)) begin
            bad++;
            $display("FAIL periodic k=%0d got s=%b want s=%b", k, spike_out,
                     ((k % (RC + 1)) == 0));
         end
         if (refrac_active) begin
            total++;
            if (membrane !== 12'd0) begin
               bad++; $display("FAIL periodic_refrac_v k=%0d got=%0d want=0", k, membrane);
            end
         end
      end
   endtask

   task automatic test_stdp_potentiation();
      int want;
      do_reset();
      step(8'h01, 1'b1, 1'b0, 0, 0);
      step(8'h00, 1'b1, 1'b0, 0, 0);
      step(8'hFF, 1'b1, 1'b0, 0, 0);
      total++;
      if (spike_out !== 1'b1) begin
         bad++; $display("FAIL pot_fire got s=%b want s=1", spike_out);
      end
      want = STDP ? 33 : 32;
      for (int i = 0; i < N; i++) begin
         wrd_idx = 3'(i); #1;
         total++;
         if (wrd_data !== 8'(want)) begin
            bad++; $display("FAIL pot_weight[%0d] got=%0d want=%0d", i, wrd_data, want);
         end
      end
   endtask

   task automatic test_stdp_depression_and_sat();
      int want;
      do_reset();
      step(8'hFF, 1'b0, 1'b0, 0, 0);
      step(8'h00, 1'b1, 1'b0, 0, 0);
      step(8'h08, 1'b1, 1'b0, 0, 0);
      for (int i = 0; i < N; i++) begin
         want = (STDP && i == 3) ? 31 : 32;
         wrd_idx = 3'(i); #1;
         total++;
         if (wrd_data !== 8'(want)) begin
            bad++; $display("FAIL dep_weight[%0d] got=%0d want=%0d", i, wrd_data, want);
         end
      end
      step(8'h00, 1'b1, 1'b1, 5, 0);
      step(8'h20, 1'b1, 1'b0, 0, 0);
      wrd_idx = 3'd5; #1;
      total++;
      if (wrd_data !== 8'd0) begin
         bad++; $display("FAIL dep_floor got=%0d want=0", wrd_data);
      end
      step(8'h00, 1'b0, 1'b1, 2, 255);
      for (int k = 0; k < 8; k++) step(8'h00, 1'b0, 1'b0, 0, 0);
      step(8'h06, 1'b1, 1'b0, 0, 0);
      total++;
      if (spike_out !== 1'b1) begin
         bad++; $display("FAIL sat_fire got s=%b want s=1", spike_out);
      end
      wrd_idx = 3'd2; #1;
      total++;
      if (wrd_data !== 8'd255) begin
         bad++; $display("FAIL pot_ceiling got=%0d want=255", wrd_data);
      end
      wrd_idx = 3'd1; #1;
      total++;
      if (wrd_data !== 8'(STDP ? 33 : 32)) begin
         bad++; $display("FAIL pot_neighbour got=%0d want=%0d", wrd_data, STDP ? 33 : 32);
      end
   endtask

   task automatic test_random();
      logic [7:0] in;
      int ri, dat;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         in  = 8'($urandom) & 8'($urandom);
         dat = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                           : $urandom_range(0, 255);
         step(in, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
              $urandom_range(0, N - 1), dat);
         total++;
         if (membrane !== 12'(m_v) || spike_out !== (m_spike != 0) ||
             refrac_active !== (m_left > 0)) begin
            bad++;
            $display("FAIL random c=%0d got v=%0d s=%b r=%b want v=%0d s=%0d r=%0d",
                     c, membrane, spike_out, refrac_active, m_v, m_spike, (m_left > 0));
         end
         ri = $urandom_range(0, N - 1);
         wrd_idx = 3'(ri); #1;
         total++;
         if (wrd_data !== 8'(m_w[ri])) begin
            bad++; $display("FAIL random_weight c=%0d idx=%0d got=%0d want=%0d",
                            c, ri, wrd_data, m_w[ri]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(8'h00, 1'b0, 1'b1, 0, 77);
      step(8'hFF, 1'b1, 1'b0, 0, 0);
      total++;
      if (spike_out !== 1'b1 || refrac_active !== 1'b1) begin
         bad++; $display("FAIL async_pre got s=%b r=%b want s=1 r=1", spike_out, refrac_active);
      end
      wrd_idx = 3'd0;
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (spike_out !== 1'b0 || refrac_active !== 1'b0 || membrane !== 12'd0) begin
         bad++;
         $display("FAIL async_reset got s=%b r=%b v=%0d want s=0 r=0 v=0",
                  spike_out, refrac_active, membrane);
      end
      total++;
      if (wrd_data !== 8'(WI)) begin
         bad++; $display("FAIL async_weight0 got=%0d want=%0d", wrd_data, WI);
      end
      wrd_idx = 3'd1; #1;
      total++;
      if (wrd_data !== 8'(WI)) begin
         bad++; $display("FAIL async_weight1 got=%0d want=%0d", wrd_data, WI);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(8'h0F, 1'b0, 1'b0, 0, 0);
      total++;
      if (membrane !== 12'd128 || refrac_active !== 1'b0) begin
         bad++;
         $display("FAIL async_resume got v=%0d r=%b want v=128 r=0", membrane, refrac_active);
      end
   endtask

   initial begin
      test_reset();
      test_single_fire();
      test_leak();
      test_periodic();
      test_stdp_potentiation();
      test_stdp_depression_and_sat();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lif_neuron_stdp.md
Name: lif_neuron_stdp

Overview:
- Parametrised leaky integrate-and-fire neuron; next generation of the 8-input neuron.
- N_INPUTS synapses with stored weights, weighted-sum integration and a saturating membrane.
- Adds a programmable threshold, shift-based leak, refractory period, trace-based STDP learning, and a weight load/readback port.
- Instantiated per neuron inside the network array. Its spike_out feeds downstream neuron inputs.

Parameters:
- N_INPUTS, 8: number of presynaptic inputs (≥2).
- W_WIDTH, 8: weight width, unsigned.
- V_WIDTH, 12: membrane potential width, unsigned.
- THRESHOLD, 256: firing threshold (1..2^V_WIDTH-1).
- LEAK_SHIFT, 3: leak = v>>LEAK_SHIFT per cycle; 0 disables leak.
- REFRAC_CYCLES, 4: refractory length in cycles (0 allowed).
- TRACE_WIDTH, 3: STDP trace counter width; TRACE_MAX = 2^TRACE_WIDTH-1.
- W_INIT, 32: reset value of every weight.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- inputs  in  N_INPUTS  presynaptic spikes, one bit per synapse, sampled each edge.
- learn  in  1  enables STDP weight updates.
- wload_en  in  1  weight write strobe.
- wload_idx  in  clog2(N_INPUTS)  weight index for write.
- wload_data  in  W_WIDTH  weight write value.
- wrd_idx  in  clog2(N_INPUTS)  readback index.
- wrd_data  out  W_WIDTH  combinational readback of weight[wrd_idx].
- spike_out  out  1  registered one-cycle spike pulse.
- membrane  out  V_WIDTH  current membrane register.
- refrac_active  out  1  high while in REFRACTORY.

Behaviour:
- Reset: membrane=0, spike_out=0, refrac_active=0, state=INTEGRATE, refractory counter=0, all traces=0, all weights=W_INIT.
- States: INTEGRATE and REFRACTORY.
- INTEGRATE, each edge:
  - sum = Σ weight[i] over set inputs[i], using pre-edge weights. Sum is computed at full width with no overflow.
  - v_next = v - (v>>LEAK_SHIFT) + sum, saturating at 2^V_WIDTH-1.
  - fire = (v_next ≥ THRESHOLD).
  - On fire: membrane←0, spike_out←1, counter←REFRAC_CYCLES, and state←REFRACTORY if REFRAC_CYCLES>0, otherwise remain in INTEGRATE.
  - Otherwise: membrane←v_next, spike_out←0.
- Latency: spike_out rises the cycle after the inputs that crossed threshold.
- REFRACTORY:
  - inputs are not integrated; membrane held 0; spike_out=0; refrac_active=1.
  - counter decrements each edge; on the edge where counter=1, state←INTEGRATE.
  - Net effect: exactly REFRAC_CYCLES cycles of refractoriness.
- Traces (always active, independent of state):
  - pre_trace[i] ← TRACE_MAX if inputs[i], else saturating decrement to 0.
  - post_trace ← TRACE_MAX on fire, else saturating decrement.
- STDP (learn=1), per synapse i on the same edge:
  - Potentiation: fire && (pre_trace[i]≠0 || inputs[i]) → +1.
  - Depression: inputs[i] && post_trace≠0 → −1.
  - Both in the same cycle → net 0.
  - Weights saturate at 0 and 2^W_WIDTH-1.
  - Depression applies during REFRACTORY too.
- Weight load:
  - wload_en writes weight[wload_idx] at the edge.
  - It takes priority over the STDP update for that index only; other indices still learn.
  - wload_idx ≥ N_INPUTS → write ignored.
- wrd_idx ≥ N_INPUTS → wrd_data=0.
- Saturated membrane with THRESHOLD ≤ max always fires.
- Reset mid-REFRACTORY or mid-spike returns everything to the reset values immediately, asynchronously.

Optional Feature:
- Macro NEURON_STDP_EN.
- Defined: traces and STDP logic built as above.
- Undefined: no trace registers; learn ignored. Weights change only via wload_en. All other behaviour identical.

Test Plan:
- Reset, then inputs=8'hFF for 1 cycle (weights 32, sum 256) → spike_out=1 next cycle; membrane=0; refrac_active=1 for 4 cycles.
- inputs=8'h0F for 1 cycle, then 8'h00 → membrane 128, 112, 98, 86 on successive cycles; spike_out stays 0.
- Hold inputs=8'hFF constantly → spike_out pulses once every 5 cycles (REFRAC_CYCLES+1); membrane=0 throughout REFRACTORY.
- learn=1: inputs=8'h01 at t, 8'h00 at t+1, 8'hFF at t+2 → fire; wrd_data=33 for all indices; without NEURON_STDP_EN all stay 32.
- learn=1: after a fire, pulse inputs=8'h08 two cycles later → weight[3]=31, others unchanged. Load weight[5]=0, then depress it → remains 0. Load weight[2]=255, then potentiate it → remains 255.
- Assert reset while refrac_active=1 with membrane/weights modified → all outputs, weights (32) and state return to reset values without waiting for a clock edge.
